gshare_dir_predictor: RTL and testbench
=======================================

// Module: gshare_dir_predictor
// PURPOSE
//  Parametrised conditional-branch direction predictor for the IF stage. Successor to the
//  fixed 256-entry bimodal PHT: configurable table depth, counter width and history length.
//  Adds a gshare mode with a speculative global history register (GHR) and checkpoint
//  restore on mispredict. Sweeps the PHT to its reset value over multiple cycles, so large
//  tables stay single-write-port RAM. BTB/RAS target selection stays outside this block.
// PARAMETERS
//  PHT_SIZE  1024       number of counter entries; power of two, >= 16
//  CTR_W     2          saturating counter width, 2..4
//  GHR_LEN   8          global history bits; 1 <= GHR_LEN <= $clog2(PHT_SIZE) (elaboration check)
//  MODE      BP_GSHARE  BP_BIMODAL: index = pc only; BP_GSHARE: index = pc XOR history
// PORTS
//  clk               in   1        clock
//  reset_n           in   1        synchronous reset, active-low
//  predict_valid     in   1        IF presents a conditional branch this cycle
//  predict_pc        in   XLEN     PC of that branch
//  predict_taken     out  1        combinational direction prediction
//  predict_ghr       out  GHR_LEN  GHR value used for this prediction; travels with the instr
//  ready             out  1        PHT initialisation complete
//  update_valid      in   1        EX resolves a conditional branch
//  update_pc         in   XLEN     PC of the resolved branch
//  update_ghr        in   GHR_LEN  predict_ghr captured at prediction time
//  update_taken      in   1        actual outcome
//  update_mispredict in   1        direction was mispredicted; restore GHR
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n.
//  Index: IW = $clog2(PHT_SIZE); pc_idx = pc[IW+1:2].
//   BP_GSHARE: idx = pc_idx ^ {{(IW-GHR_LEN){1'b0}}, ghr}. BP_BIMODAL: idx = pc_idx.
//   Predict side uses predict_pc with the live GHR. Update side uses update_pc with update_ghr.
//  Counter: reset value RV = 2**(CTR_W-1)-1 (weak not-taken). Predict taken iff MSB = 1.
//   On taken, increment and saturate at 2**CTR_W-1. On not-taken, decrement and saturate at 0.
//  FSM states:
//   S_INIT: on reset_n=0, go to S_INIT with init_idx=0, ghr=0, ready=0.
//    In S_INIT, write RV to pht[init_idx] and increment init_idx, one entry per cycle.
//    After writing entry PHT_SIZE-1, go to S_READY. Init takes exactly PHT_SIZE cycles after release.
//   S_READY: ready=1. Stays here until the next reset.
//  Outputs while reset_n=0 or in S_INIT: predict_taken=0, predict_ghr=0, ready=0.
//   predict_valid and update_valid are ignored.
//  Reset mid-init: init restarts at index 0. The full PHT_SIZE-cycle sweep repeats.
//  Prediction: latency 0. predict_taken = MSB of pht[idx] when predict_valid && ready, else 0.
//  GHR update, when ready:
//   update_valid && update_mispredict: ghr <= {update_ghr[GHR_LEN-2:0], update_taken}.
//    This has priority over a same-cycle prediction, which is on the wrong path.
//   else if predict_valid: ghr <= {ghr[GHR_LEN-2:0], predict_taken}, a speculative shift.
//   GHR_LEN = 1: the shift degenerates to ghr <= taken bit.
//   BP_BIMODAL: GHR is still maintained, but the index ignores it.
//  PHT update: on update_valid && ready, write the new counter at the update idx.
//   This happens whether or not update_mispredict is set.
//  Same-cycle predict and update to the same idx: the prediction reads the pre-update
//   value; no bypass.
// STRUCTURE
//  riscv_pkg additions: typedef enum logic {BP_BIMODAL, BP_GSHARE} bp_mode_e.
//   Also the FSM enum bp_init_state_e {S_INIT, S_READY}.
//  One sub-module: bp_pht_ram. PHT_SIZE x CTR_W, one async read port, one sync write port.
//   The write port is muxed between the init sweep and the training update.
//  Saturating increment/decrement lives in a local function; there is no separate module.
// TESTING
//  1. Init: reset_n=0 for 3 cycles, then 1 -> ready=0 for 1024 cycles, ready=1 on cycle 1024.
//     predict_taken=0 on every cycle before ready.
//  2. Bimodal saturation, pc=0x100:
//     3x update_taken=1 -> predict_taken=1.
//     Then 1x not-taken -> predict_taken=1 (counter=2). Another not-taken -> predict_taken=0.
//  3. Speculative GHR: ready, ghr=0x00, predict at a PC trained taken.
//     Next cycle predict_ghr=0x01. A second taken prediction gives 0x03.
//  4. Restore priority: predict_valid=1 together with update_mispredict=1,
//     update_ghr=0xA5, update_taken=0 -> next predict_ghr=0x4A.
//  5. Reset mid-init: drop reset_n at init cycle 500 for 1 cycle -> ready rises exactly
//     1024 cycles after release. All entries read RV.
//  6. Gshare de-aliasing: train pc=0x200 taken with ghr=0x00 and not-taken with ghr=0xFF.
//     Predictions differ per history. In BP_BIMODAL both predictions are equal.

Source files
------------

// File: rtl/gshare_dir_predictor_pkg.sv
// Shared types and helpers for the conditional-branch direction predictor.
// Imported by the predictor top and its counter-table RAM.
package gshare_dir_predictor_pkg;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } bp_init_state_e;

    localparam int BP_MIN_PHT_SIZE = 16;

    function automatic bit is_pow2(int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/gshare_dir_predictor_if.sv
// Predict (IF stage) and resolve (EX stage) signal bundle of the direction predictor.
// The pipeline side is the master; the predictor is the slave.
interface gshare_dir_predictor_if #(
    parameter int XLEN    = 32,
    parameter int GHR_LEN = 8
);
    logic               predict_valid;
    logic [XLEN-1:0]    predict_pc;
    logic               predict_taken;
    logic [GHR_LEN-1:0] predict_ghr;
    logic               ready;
    logic               update_valid;
    logic [XLEN-1:0]    update_pc;
    logic [GHR_LEN-1:0] update_ghr;
    logic               update_taken;
    logic               update_mispredict;

    modport master (
        output predict_valid, predict_pc,
        output update_valid, update_pc, update_ghr, update_taken, update_mispredict,
        input  predict_taken, predict_ghr, ready
    );

    modport slave (
        input  predict_valid, predict_pc,
        input  update_valid, update_pc, update_ghr, update_taken, update_mispredict,
        output predict_taken, predict_ghr, ready
    );
endinterface

// File: rtl/gshare_dir_predictor_bp_pht_ram.sv
// Counter table storage: DEPTH x WIDTH, one asynchronous read port, one synchronous write port.
// Contents are cleared by the owner's init sweep, so the array itself has no reset.
module bp_pht_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/gshare_dir_predictor.sv
// Bimodal / gshare direction predictor with speculative global history and mispredict
// restore; the counter table is swept to weak-not-taken after every reset.
module gshare_dir_predictor
    import gshare_dir_predictor_pkg::*;
#(
    parameter int       PHT_SIZE = 1024,
    parameter int       CTR_W    = 2,
    parameter int       GHR_LEN  = 8,
    parameter bp_mode_e MODE     = BP_GSHARE,
    parameter int       XLEN     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    gshare_dir_predictor_if.slave bus
);
    localparam int               IW      = $clog2(PHT_SIZE);
    localparam logic [CTR_W-1:0] RV      = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    if (!is_pow2(PHT_SIZE) || PHT_SIZE < BP_MIN_PHT_SIZE) begin : g_bad_size
        $error("PHT_SIZE must be a power of two >= 16");
    end
    if (CTR_W < 2 || CTR_W > 4) begin : g_bad_ctr
        $error("CTR_W must be in 2..4");
    end
    if (GHR_LEN < 1 || GHR_LEN > IW || $bits(bus.predict_ghr) != GHR_LEN) begin : g_bad_ghr
        $error("GHR_LEN must be in 1..clog2(PHT_SIZE) and match the interface");
    end
    if (XLEN < IW + 2 || $bits(bus.predict_pc) != XLEN) begin : g_bad_xlen
        $error("XLEN too narrow for the PHT index or mismatched with the interface");
    end

    function automatic logic [CTR_W-1:0] sat_step(logic [CTR_W-1:0] ctr, logic up);
        if (up) begin
            return (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
        end
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

    function automatic logic [IW-1:0] make_idx(logic [IW-1:0] pc_idx, logic [GHR_LEN-1:0] hist);
        if (MODE == BP_GSHARE) begin
            return pc_idx ^ IW'(hist);
        end
        return pc_idx;
    endfunction

    bp_init_state_e     state_reg, state_next;
    logic [IW-1:0]      init_idx_reg;
    logic [GHR_LEN-1:0] ghr_reg, ghr_next;
    logic [GHR_LEN-1:0] ghr_spec, ghr_restore;
    logic               ready;
    logic               we;
    logic [IW-1:0]      waddr;
    logic [CTR_W-1:0]   wdata;
    logic [IW-1:0]      rd_idx [2];
    logic [CTR_W-1:0]   rd_ctr [2];
    logic               unused_pc_bits;

    assign unused_pc_bits = ^{bus.predict_pc[XLEN-1:IW+2], bus.predict_pc[1:0],
                              bus.update_pc[XLEN-1:IW+2], bus.update_pc[1:0]};

    // Replica 0 serves the zero-latency prediction, replica 1 the training read-modify-write.
    assign rd_idx[0] = make_idx(bus.predict_pc[IW+1:2], ghr_reg);
    assign rd_idx[1] = make_idx(bus.update_pc[IW+1:2], bus.update_ghr);

    for (genvar gi = 0; gi < 2; gi++) begin : g_pht
        bp_pht_ram #(.DEPTH(PHT_SIZE), .WIDTH(CTR_W)) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (rd_idx[gi]),
            .rdata (rd_ctr[gi])
        );
    end

    if (GHR_LEN == 1) begin : g_ghr_1
        assign ghr_spec    = bus.predict_taken;
        assign ghr_restore = bus.update_taken;
    end else begin : g_ghr_n
        assign ghr_spec    = {ghr_reg[GHR_LEN-2:0], bus.predict_taken};
        assign ghr_restore = {bus.update_ghr[GHR_LEN-2:0], bus.update_taken};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= S_INIT;
            init_idx_reg <= '0;
            ghr_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            init_idx_reg <= (state_reg == S_INIT) ? init_idx_reg + 1'b1 : init_idx_reg;
            ghr_reg      <= ghr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == S_INIT && init_idx_reg == IW'(PHT_SIZE - 1)) begin
            state_next = S_READY;
        end
    end

    always_comb begin
        ready             = reset_n && (state_reg == S_READY);
        bus.ready         = ready;
        bus.predict_taken = ready && bus.predict_valid && rd_ctr[0][CTR_W-1];
        bus.predict_ghr   = ready ? ghr_reg : '0;
    end

    // A resolving mispredict overrides any same-cycle prediction, which is wrong-path.
    always_comb begin
        ghr_next = ghr_reg;
        if (ready) begin
            if (bus.update_valid && bus.update_mispredict) begin
                ghr_next = ghr_restore;
            end else if (bus.predict_valid) begin
                ghr_next = ghr_spec;
            end
        end
    end

    always_comb begin
        if (state_reg == S_INIT) begin
            we    = reset_n;
            waddr = init_idx_reg;
            wdata = RV;
        end else begin
            we    = ready && bus.update_valid;
            waddr = rd_idx[1];
            wdata = sat_step(rd_ctr[1], bus.update_taken);
        end
    end
endmodule

// File: tb/tb_gshare_dir_predictor.sv
// Directed bench: a gshare and a bimodal predictor driven with identical stimulus.
// Covers init length, mid-init reset, saturation, speculative GHR, restore and de-aliasing.
module tb_gshare_dir_predictor;
    import gshare_dir_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pv;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic [7:0]  ughr;
    logic        ut;
    logic        um;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    gshare_dir_predictor_if #(.XLEN(32), .GHR_LEN(8)) bus_g ();
    gshare_dir_predictor_if #(.XLEN(32), .GHR_LEN(8)) bus_b ();

    assign bus_g.predict_valid     = pv;
    assign bus_g.predict_pc        = ppc;
    assign bus_g.update_valid      = uv;
    assign bus_g.update_pc         = upc;
    assign bus_g.update_ghr        = ughr;
    assign bus_g.update_taken      = ut;
    assign bus_g.update_mispredict = um;
    assign bus_b.predict_valid     = pv;
    assign bus_b.predict_pc        = ppc;
    assign bus_b.update_valid      = uv;
    assign bus_b.update_pc         = upc;
    assign bus_b.update_ghr        = ughr;
    assign bus_b.update_taken      = ut;
    assign bus_b.update_mispredict = um;

    gshare_dir_predictor #(.PHT_SIZE(1024), .CTR_W(2), .GHR_LEN(8), .MODE(BP_GSHARE), .XLEN(32))
        dut_g (.clk(clk), .reset_n(reset_n), .bus(bus_g));
    gshare_dir_predictor #(.PHT_SIZE(1024), .CTR_W(2), .GHR_LEN(8), .MODE(BP_BIMODAL), .XLEN(32))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        uv;
        logic [31:0] upc;
        logic [7:0]  ughr;
        logic        ut;
        logic        um;
        logic        exp_pt_g;
        logic        exp_pt_b;
        logic [7:0]  exp_ghr_g;
        logic [7:0]  exp_ghr_b;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(logic p, logic [31:0] pp, logic u, logic [31:0] up, logic [7:0] uh,
                                logic t, logic m, logic eg, logic eb, logic [7:0] hg, logic [7:0] hb);
        vec_t v;
        v.pv = p; v.ppc = pp; v.uv = u; v.upc = up; v.ughr = uh; v.ut = t; v.um = m;
        v.exp_pt_g = eg; v.exp_pt_b = eb; v.exp_ghr_g = hg; v.exp_ghr_b = hb;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(logic p, logic [31:0] pp, logic u, logic [31:0] up, logic [7:0] uh,
                              logic t, logic m);
        pv = p; ppc = pp; uv = u; upc = up; ughr = uh; ut = t; um = m;
    endtask

    // Entered just after a negedge where reset_n was released; leaves inputs idle.
    task automatic check_init(string tag);
        for (int i = 0; i <= 1024; i++) begin
            #1;
            check({tag, "_ready_g"}, 32'(bus_g.ready), 32'(i == 1024));
            check({tag, "_ready_b"}, 32'(bus_b.ready), 32'(i == 1024));
            check({tag, "_pt_g"}, 32'(bus_g.predict_taken), 32'(0));
            check({tag, "_pt_b"}, 32'(bus_b.predict_taken), 32'(0));
            check({tag, "_ghr_g"}, 32'(bus_g.predict_ghr), 32'(0));
            if (i < 1024) @(negedge clk);
        end
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        $display("%s: ready rose after 1024 cycles", tag);
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        vecs[1]  = mk(0, 0, 1, 32'h100, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[2]  = mk(0, 0, 1, 32'h100, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[3]  = mk(0, 0, 1, 32'h100, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[4]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
        vecs[5]  = mk(1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 8'h01, 8'h01);
        vecs[6]  = mk(1, 32'h100, 1, 32'hF00, 8'hA5, 0, 1, 0, 1, 8'h03, 8'h02);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h4A, 8'h4A);
        vecs[8]  = mk(0, 0, 1, 32'h100, 8'h00, 0, 0, 0, 0, 8'h4A, 8'h4A);
        vecs[9]  = mk(0, 0, 1, 32'hF00, 8'h00, 0, 1, 0, 0, 8'h4A, 8'h4A);
        vecs[10] = mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
        vecs[11] = mk(0, 0, 1, 32'h100, 8'h00, 0, 1, 0, 0, 8'h01, 8'h01);
        vecs[12] = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        vecs[13] = mk(0, 0, 1, 32'h200, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[14] = mk(0, 0, 1, 32'h200, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00);
        vecs[15] = mk(0, 0, 1, 32'h200, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[16] = mk(0, 0, 1, 32'h200, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00);
        vecs[17] = mk(0, 0, 1, 32'h200, 8'h00, 1, 0, 0, 0, 8'h00, 8'h00);
        vecs[18] = mk(1, 32'h200, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
        vecs[19] = mk(0, 0, 1, 32'hF00, 8'hFF, 1, 1, 0, 0, 8'h01, 8'h01);
        vecs[20] = mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 8'hFF, 8'hFF);
        vecs[21] = mk(1, 32'h100, 1, 32'h100, 8'h00, 1, 0, 0, 0, 8'hFE, 8'hFF);
        vecs[22] = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 8'hFC, 8'hFE);

        // Reset for three cycles with predict/restore activity that must be ignored.
        reset_n = 1'b0;
        set_inputs(1, 32'h100, 1, 32'h100, 8'hA5, 1, 1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_ready_g", 32'(bus_g.ready), 32'(0));
            check("rst_pt_g", 32'(bus_g.predict_taken), 32'(0));
            check("rst_ghr_b", 32'(bus_b.predict_ghr), 32'(0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        check_init("init");
        @(negedge clk);

        for (int k = 0; k < 23; k++) begin
            set_inputs(vecs[k].pv, vecs[k].ppc, vecs[k].uv, vecs[k].upc, vecs[k].ughr,
                       vecs[k].ut, vecs[k].um);
            #1;
            check($sformatf("vec%0d_pt_g", k), 32'(bus_g.predict_taken), 32'(vecs[k].exp_pt_g));
            check($sformatf("vec%0d_pt_b", k), 32'(bus_b.predict_taken), 32'(vecs[k].exp_pt_b));
            check($sformatf("vec%0d_ghr_g", k), 32'(bus_g.predict_ghr), 32'(vecs[k].exp_ghr_g));
            check($sformatf("vec%0d_ghr_b", k), 32'(bus_b.predict_ghr), 32'(vecs[k].exp_ghr_b));
            $display("vec %0d: pt_g=%0d pt_b=%0d ghr_g=0x%02h ghr_b=0x%02h", k,
                     bus_g.predict_taken, bus_b.predict_taken, bus_g.predict_ghr, bus_b.predict_ghr);
            @(negedge clk);
        end

        // Reset, then pulse reset again 500 cycles into the sweep.
        set_inputs(1, 32'h200, 1, 32'h100, 8'h00, 1, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            #1;
            check("mid_ready_g", 32'(bus_g.ready), 32'(0));
            check("mid_ready_b", 32'(bus_b.ready), 32'(0));
            @(negedge clk);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_init("reinit");
        @(negedge clk);

        // Every entry must be below the taken threshold after the sweep.
        for (int i = 0; i < 1024; i++) begin
            set_inputs(1, 32'(i) << 2, 0, 0, 0, 0, 0);
            #1;
            check($sformatf("sweep%0d_pt_g", i), 32'(bus_g.predict_taken), 32'(0));
            check($sformatf("sweep%0d_pt_b", i), 32'(bus_b.predict_taken), 32'(0));
            @(negedge clk);
        end
        $display("sweep: 1024 entries predicted not-taken");

        // One taken update from the reset value must cross the taken threshold.
        set_inputs(0, 0, 1, 32'h100, 8'h00, 1, 0);
        @(negedge clk);
        set_inputs(1, 32'h100, 0, 0, 0, 0, 0);
        #1;
        check("rv_pt_g", 32'(bus_g.predict_taken), 32'(1));
        check("rv_pt_b", 32'(bus_b.predict_taken), 32'(1));
        check("rv_ghr_g", 32'(bus_g.predict_ghr), 32'(0));
        $display("rv step: pt_g=%0d pt_b=%0d", bus_g.predict_taken, bus_b.predict_taken);
        @(negedge clk);
        set_inputs(0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
